lfsr_mod_ctrl: RTL

LFSR_MOD_CTRL -- requirements
Module: lfsr_mod_ctrl

---
 rtl/lab5_mod_pkg.sv | 20 ++
 rtl/sync2.sv | 21 ++
 rtl/lfsr_mod_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/lab5_mod_pkg.sv
// Shared types and default tone increments for the LFSR-driven modulation controller.
package lab5_mod_pkg;

    typedef enum logic [1:0] {
        ASK     = 2'b00,
        FSK     = 2'b01,
        BPSK    = 2'b10,
        CARRIER = 2'b11
    } mod_sel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_WRAP = 2'b01,
        APPLY     = 2'b10
    } state_t;

    localparam int unsigned DEF_INC_LO = 25770;
    localparam int unsigned DEF_INC_HI = 257698;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lfsr_mod_ctrl.sv
// Applies LFSR bit / modulation-select changes to the DDS only on a phase wrap
// (or after a bounded wait), so tone and polarity switches stay phase-continuous.
module lfsr_mod_ctrl
    import lab5_mod_pkg::*;
#(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned INC_LO  = DEF_INC_LO,
    parameter int unsigned INC_HI  = DEF_INC_HI,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         lfsr_q,
    input  logic [1:0]         mod_sel,
    input  logic               phase_wrap,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               ask_en,
    output logic               bpsk_neg,
    output logic               bit_now,
    output logic               update_pulse
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PHASE_W-1:0] PINC_LO = PHASE_W'(INC_LO);
    localparam logic [PHASE_W-1:0] PINC_HI = PHASE_W'(INC_HI);

    logic       bit_s;
    logic [1:0] sel_s;

    sync2 u_sync_bit  (.clk(clk), .rst_n(reset), .d(lfsr_q[0]),  .q(bit_s));
    sync2 u_sync_sel0 (.clk(clk), .rst_n(reset), .d(mod_sel[0]), .q(sel_s[0]));
    sync2 u_sync_sel1 (.clk(clk), .rst_n(reset), .d(mod_sel[1]), .q(sel_s[1]));

    state_t     state, next_state;
    logic [2:0] target, applied;
    logic [CNT_W-1:0] cnt;
    logic       load, cnt_clr, cnt_inc;

    logic [PHASE_W-1:0] nxt_inc;
    logic               nxt_ask, nxt_neg;

    assign target = {sel_s, bit_s};

    always_comb begin
        next_state = state;
        load       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (target != applied) begin
                    next_state = WAIT_WRAP;
                    cnt_clr    = 1'b1;
                end
            end
            WAIT_WRAP: begin
                if (target == applied) begin
                    next_state = IDLE;
                end else if (phase_wrap || cnt == CNT_LAST) begin
                    load       = 1'b1;
                    next_state = APPLY;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            APPLY:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the target being loaded, so they register in
    // lockstep with 'applied' and never see a live input combinationally.
    always_comb begin
        nxt_inc = PINC_HI;
        nxt_ask = 1'b1;
        nxt_neg = 1'b0;
        case (mod_sel_t'(target[2:1]))
            ASK:     nxt_ask = target[0];
            FSK:     nxt_inc = target[0] ? PINC_HI : PINC_LO;
            BPSK:    nxt_neg = target[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            applied      <= {ASK, 1'b0};
            cnt          <= '0;
            phase_inc    <= PINC_HI;
            ask_en       <= 1'b0;
            bpsk_neg     <= 1'b0;
            bit_now      <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            state        <= next_state;
            update_pulse <= load;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                applied   <= target;
                phase_inc <= nxt_inc;
                ask_en    <= nxt_ask;
                bpsk_neg  <= nxt_neg;
                bit_now   <= target[0];
            end
        end
    end

endmodule
